// File: rtl/wgt_loader.sv
// -----------------------------------------------------------------------------
// wgt_loader
// Streams signed 8-bit kernel weights from an upstream valid/ready source into
// NUM_WGT weight slot registers. Weights are staged in a small FIFO, which may
// fill before a load is requested. Each start request loads one kernel. Each
// weight is broadcast on wgt_out together with a one-hot write strobe on
// wgt_read.
//
// Optional feature: define WGT_LOADER_CHECKSUM_EN to add the wgt_sum output.
// wgt_sum is a running signed sum of the weights of the current kernel.
//
// Ports
//   clk       in   clock, all logic on rising edge
//   rst       in   synchronous active-high reset
//   s_valid   in   upstream weight valid
//   s_data    in   signed 8-bit weight
//   s_ready   out  staging FIFO not full
//   start     in   single-cycle request to load one kernel
//   wgt_out   out  weight broadcast to all slot registers
//   wgt_read  out  one-hot slot write strobe (bit i loads slot i)
//   busy      out  FSM not idle
//   wgt_sum   out  (WGT_LOADER_CHECKSUM_EN only) signed sum of loaded weights
//   done      out  single-cycle pulse alongside the final strobe
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; the FIFO can still prefetch weights
// LOAD   | popping one weight per cycle while the FIFO is non-empty
// DONE   | final strobe is visible and done is high; back to IDLE next
// -----------------------------------------------------------------------------
module wgt_loader #(
  parameter int NUM_WGT    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic signed [7:0]   s_data,
  output logic                s_ready,
  input  logic                start,
  output logic signed [7:0]   wgt_out,
  output logic [NUM_WGT-1:0]  wgt_read,
  output logic                busy,
`ifdef WGT_LOADER_CHECKSUM_EN
  output logic signed [15:0]  wgt_sum,
`endif
  output logic                done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (NUM_WGT > 1) ? $clog2(NUM_WGT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               r_state;
  logic [IW-1:0]            r_idx;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic signed [7:0]        r_mem [FIFO_DEPTH];
  logic signed [7:0]        r_wgt_out;
  logic [NUM_WGT-1:0]       r_wgt_read;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last;
  logic signed [7:0]        w_head;
  logic [PW-1:0]            w_wr_nxt;
  logic [PW-1:0]            w_rd_nxt;
  logic [NUM_WGT-1:0]       w_strobe;

  // Full/empty come from the registered count only. This keeps s_ready free
  // of any same-cycle pop dependence. It also means a weight pushed into an
  // empty FIFO cannot be popped until the following cycle.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = s_valid && !w_full;
  assign w_pop    = (r_state == S_LOAD) && !w_empty;
  assign w_last   = (r_idx == IW'(NUM_WGT - 1));
  assign w_head   = r_mem[r_rd_ptr];
  assign w_wr_nxt = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_nxt = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_strobe        = '0;
    w_strobe[r_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wgt_out  <= '0;
      r_wgt_read <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      // The strobe lasts one cycle. wgt_out keeps the last weight it showed.
      r_wgt_read <= '0;
      if (w_pop) begin
        r_wgt_out  <= w_head;
        r_wgt_read <= w_strobe;
        r_idx      <= r_idx + IW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
          end
        end
        S_LOAD: begin
          if (w_pop && w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WGT_LOADER_CHECKSUM_EN
  logic signed [15:0] r_wgt_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wgt_sum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_wgt_sum <= '0;
    end else if (w_pop) begin
      r_wgt_sum <= r_wgt_sum + {{8{w_head[7]}}, w_head};
    end
  end

  assign wgt_sum = r_wgt_sum;
`endif

  assign s_ready  = !w_full;
  assign wgt_out  = r_wgt_out;
  assign wgt_read = r_wgt_read;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_wgt_loader.sv
// -----------------------------------------------------------------------------
// tb_wgt_loader
// Directed bench for wgt_loader with default parameters (9 slots, 4-deep FIFO).
// A negedge monitor logs every strobe and every done pulse. Each test then
// compares the log against hand-derived expected sequences.
// -----------------------------------------------------------------------------
module tb_wgt_loader;

  localparam int NUM_WGT    = 9;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic [7:0]         s_data;
  logic               s_ready;
  logic               start;
  logic [7:0]         wgt_out;
  logic [NUM_WGT-1:0] wgt_read;
  logic               busy;
  logic               done;
`ifdef WGT_LOADER_CHECKSUM_EN
  logic signed [15:0] wgt_sum;
`endif

  wgt_loader #(.NUM_WGT(NUM_WGT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .start    (start),
    .wgt_out  (wgt_out),
    .wgt_read (wgt_read),
    .busy     (busy),
`ifdef WGT_LOADER_CHECKSUM_EN
    .wgt_sum  (wgt_sum),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // strobe / done log
  int strb_cyc[$];
  int strb_val[$];
  int strb_wgt[$];
  int done_cyc[$];
  int st_cyc;

  always @(negedge clk) begin
    if (wgt_read != '0) begin
      strb_cyc.push_back(cyc);
      strb_val.push_back(int'(wgt_read));
      strb_wgt.push_back(int'(wgt_out));
    end
    if (done) done_cyc.push_back(cyc);
    if (start && !busy && !rst) st_cyc = cyc;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    strb_cyc.delete();
    strb_val.delete();
    strb_wgt.delete();
    done_cyc.delete();
  endtask

  int wdat[9];
  int nw = 9;
  bit acc_log[64];

  // Per cycle: raise start on st1/st2, and offer the next weight every
  // 'gap' cycles until all nw weights are accepted.
  task automatic run(input int ncyc, input int gap, input int st1, input int st2);
    int k = 0;
    bit acc;
    for (int i = 0; i < ncyc; i++) begin
      start   = (i == st1) || (i == st2);
      s_valid = (k < nw) && (i % gap == 0);
      s_data  = (k < nw) ? 8'(wdat[k]) : 8'h00;
      acc     = s_valid && s_ready;
      if (i < 64) acc_log[i] = acc;
      step();
      if (acc) k++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Expect 9 one-hot strobes walking bit 0..8, weights w0 + i*dw, strobes
  // 'spacing' cycles apart, and one done pulse coincident with the last strobe.
  task automatic chk_load(input string tag, input int w0, input int dw, input int spacing);
    chk({tag, "_nstrb"}, strb_cyc.size(), 9);
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    if (strb_cyc.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("%s_sel%0d", tag, i), strb_val[i], longint'(1) << i);
        chk($sformatf("%s_wgt%0d", tag, i), strb_wgt[i], (w0 + i * dw) & 255);
        if (i > 0)
          chk($sformatf("%s_gap%0d", tag, i), strb_cyc[i] - strb_cyc[i-1], spacing);
      end
      if (done_cyc.size() == 1)
        chk({tag, "_done_at_last"}, done_cyc[0], strb_cyc[8]);
    end
  endtask

  initial begin
    // reset, with start and s_valid also high to exercise reset priority
    rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 8'h55;
    step();
    step();
    start = 1'b0; s_valid = 1'b0;
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_wgt_read", wgt_read, 0);
    chk("rst_wgt_out",  wgt_out,  0);
    chk("rst_s_ready",  s_ready,  1);
    rst = 1'b0;
    step();
    chk("rst_idle_after", busy, 0);

    // basic load: prefill 1..4, start while full, remaining weights stream in
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = i + 1;
    run(18, 1, 4, -1);
    chk_load("basic", 1, 1, 1);
    if (done_cyc.size() == 1)
      chk("basic_busy_window", done_cyc[0] - st_cyc + 1, 11);
    chk("basic_idle", busy, 0);

    // underflow stall: start on empty FIFO, -3 arrives every 3rd cycle
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = -3;
    run(30, 3, 0, -1);
    chk_load("stall", -3, 0, 3);
    chk("stall_idle", busy, 0);

    // backpressure: 4 pushes fill the FIFO; the first pop does not admit a push
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = 10 + i;
    run(22, 1, 6, -1);
    chk("bp_acc0", acc_log[0], 1);
    chk("bp_acc3", acc_log[3], 1);
    chk("bp_acc4_full", acc_log[4], 0);
    chk("bp_acc6_full", acc_log[6], 0);
    chk("bp_acc7_pop_full", acc_log[7], 0);
    chk("bp_acc8", acc_log[8], 1);
    chk_load("bp", 10, 1, 1);

    // second start mid-LOAD is ignored
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = 21 + i;
    run(16, 1, 0, 4);
    chk_load("restart", 21, 1, 1);
    chk("restart_idle", busy, 0);

    // reset while the fifth strobe is visible
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = 31 + i;
    run(6, 1, 0, -1);
    chk("rmid_sel4", wgt_read, 16);
    chk("rmid_wgt4", wgt_out, 35);
    rst = 1'b1;
    step();
    chk("rmid_wgt_read", wgt_read, 0);
    chk("rmid_wgt_out",  wgt_out,  0);
    chk("rmid_busy",     busy,     0);
    chk("rmid_s_ready",  s_ready,  1);
    rst = 1'b0;
    step();
    chk("rmid_nstrb", strb_cyc.size(), 5);
    chk("rmid_ndone", done_cyc.size(), 0);
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = 41 + i;
    run(16, 1, 0, -1);
    chk_load("after_rst", 41, 1, 1);

`ifdef WGT_LOADER_CHECKSUM_EN
    // checksum: nine -128 weights sum to -1152, the next start clears it
    clr();
    for (int i = 0; i < 9; i++) wdat[i] = -128;
    run(14, 1, 0, -1);
    chk_load("sum", -128, 0, 1);
    chk("sum_total", wgt_sum, -1152);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sum_clear", wgt_sum, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("sum_rst", wgt_sum, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
